// File: rtl/car_pkg.sv
// -----------------------------------------------------------------------------
// car_pkg
// Shared definitions for the car control slice: the power/drive state
// enumeration, the 2-bit mode codes and small helpers that map between
// states, mode codes and the mode-selection switch. The start and display
// logic import the same package, so the encodings stay consistent.
// -----------------------------------------------------------------------------
package car_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STANDBY = 3'd1,
        ST_MANUAL  = 3'd2,
        ST_SEMI    = 3'd3,
        ST_AUTO    = 3'd4
    } car_state_t;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_SEMI   = 2'b10;
    localparam logic [1:0] MODE_AUTO   = 2'b11;

    // Mode code presented on the mode output for a given state.
    function automatic logic [1:0] state_to_mode(input car_state_t state);
        logic [1:0] mode_code;
        mode_code = MODE_NONE;
        case (state)
            ST_MANUAL: mode_code = MODE_MANUAL;
            ST_SEMI:   mode_code = MODE_SEMI;
            ST_AUTO:   mode_code = MODE_AUTO;
            default:   mode_code = MODE_NONE;
        endcase
        return mode_code;
    endfunction

    // State selected by the mode switch when a brake event is accepted.
    // A "none" selection parks the car in STANDBY.
    function automatic car_state_t selection_to_state(input logic [1:0] selection);
        car_state_t state;
        state = ST_STANDBY;
        case (selection)
            MODE_MANUAL: state = ST_MANUAL;
            MODE_SEMI:   state = ST_SEMI;
            MODE_AUTO:   state = ST_AUTO;
            default:     state = ST_STANDBY;
        endcase
        return state;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Brings an asynchronous, bouncy push-button into the clk domain through a
// 2-flop synchronizer and debounces it: the stability counter clears whenever
// the synchronized level changes, and the debounced output takes the new
// level once it has been stable for DEBOUNCE_CYCLES cycles.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset (debounced value -> 0)
//   raw        in   raw button level, asynchronous
//   debounced  out  debounced, synchronized level (registered)
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic debounced
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             last_reg;       // previous synchronized level, for change detection
    logic [CNT_W-1:0] cnt_reg;
    logic             debounced_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            last_reg      <= 1'b0;
            cnt_reg       <= '0;
            debounced_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            last_reg  <= sync2_reg;
            if (sync2_reg != last_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                // Counter saturates; level has been stable long enough.
                debounced_reg <= last_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign debounced = debounced_reg;

endmodule

// File: rtl/power_mode_ctrl.sv
// -----------------------------------------------------------------------------
// power_mode_ctrl
// Power and drive-mode controller. A long press of the power button toggles
// between OFF and STANDBY (or powers down from any driving mode). A brake
// press in a powered state applies the mode switch: 01 manual, 10 semi-auto,
// 11 auto, 00 back to standby. Mode switch changes without a brake press are
// ignored. A hold event beats a simultaneous brake event.
//
// Ports
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   power           in   raw power push-button (asynchronous, bouncy)
//   brake           in   raw brake button (asynchronous, bouncy)
//   mode_selection  in   [1:0] mode switch value
//   mode            out  [1:0] active mode (00 off/standby), registered
//   powered         out  high in every state except OFF, registered
// -----------------------------------------------------------------------------
module power_mode_ctrl
    import car_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic       brake,
    input  logic [1:0] mode_selection,
    output logic [1:0] mode,
    output logic       powered
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Bit 0 = power, bit 1 = brake.
    localparam int unsigned N_BUTTONS = 2;

    logic [N_BUTTONS-1:0] raw_buttons;
    logic [N_BUTTONS-1:0] db_buttons;

    assign raw_buttons = {brake, power};

    generate
        for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_button
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .rst       (rst),
                .raw       (raw_buttons[gi]),
                .debounced (db_buttons[gi])
            );
        end
    endgenerate

    logic power_db;
    logic brake_db;
    assign power_db = db_buttons[0];
    assign brake_db = db_buttons[1];

    // -------------------------------------------------------------------------
    // Event generation
    // -------------------------------------------------------------------------
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              hold_evt_reg;
    logic              brake_dly_reg;
    logic              brake_evt;

    // The hold counter saturates at HOLD_CYCLES, so the pulse fires once per
    // press and a button kept down after a toggle cannot toggle again.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg  <= '0;
            hold_evt_reg  <= 1'b0;
            brake_dly_reg <= 1'b0;
        end else begin
            hold_evt_reg  <= 1'b0;
            brake_dly_reg <= brake_db;
            if (!power_db) begin
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg != HOLD_MAX) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
                if (hold_cnt_reg == HOLD_LAST) begin
                    hold_evt_reg <= 1'b1;
                end
            end
        end
    end

    // Built only from registers, so no raw input reaches the state logic
    // combinationally.
    assign brake_evt = brake_db & ~brake_dly_reg;

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    car_state_t state_reg;
    car_state_t state_next;
    logic [1:0] mode_reg;
    logic       powered_reg;

    always_comb begin
        state_next = state_reg;
        if (hold_evt_reg) begin
            // Hold wins over a coincident brake event.
            state_next = (state_reg == ST_OFF) ? ST_STANDBY : ST_OFF;
        end else if (brake_evt && (state_reg != ST_OFF)) begin
            state_next = selection_to_state(mode_selection);
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_OFF;
            mode_reg    <= MODE_NONE;
            powered_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= state_to_mode(state_next);
            powered_reg <= (state_next != ST_OFF);
        end
    end

    assign mode    = mode_reg;
    assign powered = powered_reg;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_power_mode_ctrl
// Directed testbench for power_mode_ctrl with HOLD_CYCLES=8 and
// DEBOUNCE_CYCLES=4. From a raw edge driven just after clock edge 0, the
// debounced level follows at edge 8, the hold pulse is set at edge 16 and the
// state changes at edge 17; a brake press changes the mode at edge 9.
// -----------------------------------------------------------------------------
module tb_power_mode_ctrl;

    logic       clk;
    logic       rst;
    logic       power;
    logic       brake;
    logic [1:0] mode_selection;
    logic [1:0] mode;
    logic       powered;

    int checks_cnt;
    int errors_cnt;

    power_mode_ctrl #(
        .HOLD_CYCLES     (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .power          (power),
        .brake          (brake),
        .mode_selection (mode_selection),
        .mode           (mode),
        .powered        (powered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks_cnt++;
        if (observed !== expected) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then step 1 time unit away from the edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] exp_mode,
                             input logic exp_powered);
        check({tag, ".mode"}, 32'(mode), 32'(exp_mode));
        check({tag, ".powered"}, 32'(powered), 32'(exp_powered));
    endtask

    // Long press then release; leaves the debounced power low and settled.
    task automatic power_press;
        power = 1'b1;
        wait_cycles(20);
        power = 1'b0;
        wait_cycles(12);
    endtask

    // Brake press with the given selection; output checked after 10 edges.
    task automatic brake_press(input logic [1:0] sel, input string tag,
                               input logic [1:0] exp_mode, input logic exp_powered);
        mode_selection = sel;
        brake = 1'b1;
        wait_cycles(10);
        check_out(tag, exp_mode, exp_powered);
        brake = 1'b0;
        wait_cycles(10);
    endtask

    initial begin
        checks_cnt     = 0;
        errors_cnt     = 0;
        rst            = 1'b1;
        power          = 1'b0;
        brake          = 1'b0;
        mode_selection = 2'b00;

        // Reset state
        wait_cycles(2);
        check_out("reset", 2'b00, 1'b0);
        rst = 1'b0;
        wait_cycles(2);

        // OFF -> STANDBY with exact latency of the hold event
        power = 1'b1;
        wait_cycles(16);
        check("hold_edge16.powered", 32'(powered), 32'd0);
        wait_cycles(1);
        check_out("hold_edge17", 2'b00, 1'b1);
        wait_cycles(3);
        power = 1'b0;
        wait_cycles(12);
        check_out("standby", 2'b00, 1'b1);

        // STANDBY + brake with selection 00 stays in STANDBY
        brake_press(2'b00, "standby_sel00", 2'b00, 1'b1);

        // STANDBY + selection 10 + brake -> SEMI, with exact latency
        mode_selection = 2'b10;
        brake = 1'b1;
        wait_cycles(8);
        check("brake_edge8.mode", 32'(mode), 32'd0);
        wait_cycles(1);
        check("brake_edge9.mode", 32'(mode), 32'd2);
        wait_cycles(1);
        brake = 1'b0;
        wait_cycles(10);

        // Selection change without brake is ignored
        mode_selection = 2'b11;
        wait_cycles(5);
        check_out("sel_no_brake", 2'b10, 1'b1);

        // SEMI -> AUTO
        brake_press(2'b11, "semi_to_auto", 2'b11, 1'b1);

        // AUTO: long hold -> OFF, keep held -> stays OFF
        power = 1'b1;
        wait_cycles(20);
        check_out("auto_hold_off", 2'b00, 1'b0);
        wait_cycles(30);
        check_out("held_stays_off", 2'b00, 1'b0);
        power = 1'b0;
        wait_cycles(12);

        // Bouncing power button: 1-cycle pulses for 40 cycles
        for (int i = 0; i < 20; i++) begin
            power = 1'b1;
            wait_cycles(1);
            power = 1'b0;
            wait_cycles(1);
        end
        wait_cycles(12);
        check_out("bounce", 2'b00, 1'b0);

        // Brake while OFF does nothing
        brake_press(2'b01, "off_brake", 2'b00, 1'b0);

        // Power on, then walk through the driving modes
        power_press();
        check_out("standby2", 2'b00, 1'b1);
        brake_press(2'b01, "to_manual", 2'b01, 1'b1);
        brake_press(2'b10, "manual_to_semi", 2'b10, 1'b1);
        brake_press(2'b00, "semi_to_standby", 2'b00, 1'b1);
        brake_press(2'b01, "to_manual2", 2'b01, 1'b1);

        // MANUAL: hold and brake events coincide -> OFF (hold wins)
        mode_selection = 2'b11;
        power = 1'b1;
        wait_cycles(8);
        brake = 1'b1;
        wait_cycles(12);
        check_out("coincide", 2'b00, 1'b0);
        power = 1'b0;
        brake = 1'b0;
        wait_cycles(12);

        // SEMI: reset mid-hold, then a full new hold is needed
        power_press();
        brake_press(2'b10, "to_semi", 2'b10, 1'b1);
        power = 1'b1;
        wait_cycles(14);
        rst = 1'b1;
        wait_cycles(2);
        check_out("rst_mid_hold", 2'b00, 1'b0);
        rst = 1'b0;
        wait_cycles(16);
        check("after_rst_edge16.powered", 32'(powered), 32'd0);
        wait_cycles(1);
        check_out("after_rst_edge17", 2'b00, 1'b1);
        power = 1'b0;
        wait_cycles(12);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/power_mode_ctrl.md
POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 100_000_000, debounced-power hold time (cycles) to toggle power.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2_000_000, cycles an input must stay stable before its debounced value updates.
REQ-003 Port clk  input  1  system clock; every register SHALL update on its rising edge only.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port power  input  1  raw power push-button, asynchronous, bouncy.
REQ-006 Port brake  input  1  raw brake button, asynchronous, bouncy.
REQ-007 Port mode_selection  input  2  switch value: 01 manual, 10 semi-auto, 11 auto, 00 none.
REQ-008 Port mode  output  2  active mode: 00 off/standby, 01 manual, 10 semi-auto, 11 auto.
REQ-009 Port powered  output  1  high in every state except OFF.

Function
REQ-010 power and brake SHALL each pass through a 2-flop synchronizer, then a debouncer.
REQ-011 Debouncer: counter clears on any synchronized-input change; debounced value takes the input when the count reaches DEBOUNCE_CYCLES.
REQ-012 Hold counter SHALL count while debounced power is high, saturate at HOLD_CYCLES and clear on release.
REQ-013 hold_evt SHALL pulse one cycle when the hold counter first reaches HOLD_CYCLES; no further pulse until power is released.
REQ-014 brake_evt SHALL pulse one cycle on each debounced-brake rising edge.
REQ-015 States: OFF, STANDBY, MANUAL, SEMI, AUTO; encoding held in the shared package.
REQ-016 OFF: mode=00, powered=0; hold_evt -> STANDBY.
REQ-017 STANDBY: mode=00, powered=1; brake_evt with mode_selection 01/10/11 -> MANUAL/SEMI/AUTO; brake_evt with 00 -> stay.
REQ-018 MANUAL/SEMI/AUTO: mode = 01/10/11.
REQ-019 In a driving state, brake_evt with mode_selection 00 -> STANDBY.
REQ-020 In a driving state, brake_evt with a different non-zero selection -> that mode.
REQ-021 In a driving state, a mode_selection change without brake_evt SHALL be ignored.
REQ-022 hold_evt in any non-OFF state -> OFF.
REQ-023 hold_evt and brake_evt in the same cycle: hold_evt wins; brake_evt is discarded.
REQ-024 State transition SHALL occur on the clock edge after the event pulse.
REQ-025 mode and powered SHALL be registered, decoded from state, with no combinational path from raw inputs.
REQ-026 Power held continuously after OFF->STANDBY SHALL NOT power off again until released and re-held.

Reset
REQ-027 rst SHALL force state=OFF, mode=00, powered=0.
REQ-028 rst SHALL clear all synchronizer, debouncer and hold counters, and set the debounced values to 0.
REQ-029 rst asserted mid-hold or mid-debounce SHALL abandon the count; a new full HOLD_CYCLES hold is required after release of rst.

Structure
REQ-030 The state enumeration and the mode codes (00/01/10/11) SHALL live in the shared car package, reused by the start and display logic.
REQ-031 Debounce+synchronizer SHALL be one sub-module, button_debounce, instantiated twice and parameterized by DEBOUNCE_CYCLES.
REQ-032 Counter widths SHALL derive from $clog2 of the parameters.

Verification (HOLD_CYCLES=8, DEBOUNCE_CYCLES=4)
REQ-033 rst high 2 cycles -> mode=00, powered=0; power held 20 cycles then released -> powered=1, mode=00.
REQ-034 In STANDBY, mode_selection=10 plus brake pulse 10 cycles -> mode=10; then selection changed to 11 without brake -> mode stays 10.
REQ-035 In AUTO, power held 20 cycles -> OFF with mode=00, powered=0; power kept held 30 more cycles -> stays OFF.
REQ-036 Power bouncing 1-cycle pulses for 40 cycles -> no state change.
REQ-037 Power release and brake edge timed so hold_evt and brake_evt coincide in MANUAL -> OFF.
REQ-038 In SEMI, rst asserted with power held 6 cycles -> OFF; rst released with power still held -> OFF until 8+ further debounced hold cycles.
